// File: rtl/booth_mul_pkg.sv
// Shared state/digit types and iteration-count helper for the sequential Booth multiplier.
// Build option: define BOOTH_MUL_RADIX4_EN for radix-4 modified Booth recoding.
package booth_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_POS1,
    DIG_NEG1,
    DIG_POS2,
    DIG_NEG2
  } booth_digit_t;

`ifdef BOOTH_MUL_RADIX4_EN
  localparam int BOOTH_SHIFT = 2;
`else
  localparam int BOOTH_SHIFT = 1;
`endif

  localparam int BOOTH_WIN_W = BOOTH_SHIFT + 1;

  function automatic int booth_iter(input int width);
`ifdef BOOTH_MUL_RADIX4_EN
    return width / 2 + 1;
`else
    return width + 1;
`endif
  endfunction

  // Radix-2 windows {q0,q-1} are presented as {q0,q0,q-1}, which decodes identically.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return DIG_POS1;
      3'b011:         return DIG_POS2;
      3'b100:         return DIG_NEG2;
      3'b101, 3'b110: return DIG_NEG1;
      default:        return DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_recoder.sv
// Combinational Booth recoder: turns the multiplier window into a signed addend of M.
// Window width follows BOOTH_MUL_RADIX4_EN (3 bits when defined, 2 bits otherwise).
module booth_recoder
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [BOOTH_WIN_W-1:0] i_window,
  input  logic [WIDTH:0]         i_m,
  output logic [WIDTH+2:0]       o_addend
);

  logic [2:0]       w_triplet;
  logic [WIDTH+2:0] w_mExt;
  booth_digit_t     w_digit;

`ifdef BOOTH_MUL_RADIX4_EN
  assign w_triplet = i_window;
`else
  assign w_triplet = {i_window[1], i_window};
`endif

  assign w_mExt  = {{2{i_m[WIDTH]}}, i_m};
  assign w_digit = booth_decode(w_triplet);

  always_comb begin
    o_addend = '0;
    case (w_digit)
      DIG_POS1: o_addend = w_mExt;
      DIG_NEG1: o_addend = -w_mExt;
      DIG_POS2: o_addend = w_mExt << 1;
      DIG_NEG2: o_addend = -(w_mExt << 1);
      default:  o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle Booth multiplier with start/ready handshake and run-time signed/unsigned operands.
// Define BOOTH_MUL_RADIX4_EN for radix-4 recoding: same results, fewer iterations.
module booth_multiplier_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] Output,
  output logic               ready,
  output logic               busy
);

  localparam int ITER = booth_iter(WIDTH);
  localparam int QW   = ITER * BOOTH_SHIFT;
  localparam int AW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);

  state_t             r_state;
  logic [AW-1:0]      r_acc;
  logic [QW-1:0]      r_q;
  logic               r_qm1;
  logic [WIDTH:0]     r_m;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_out;
  logic               r_ready;
  logic               r_busy;

  logic [BOOTH_WIN_W-1:0] w_window;
  logic [AW-1:0]          w_addend;
  logic [AW-1:0]          w_sum;
  logic [AW+QW:0]         w_shifted;
  logic [WIDTH:0]         w_mInit;
  logic [QW-1:0]          w_qInit;

`ifdef BOOTH_MUL_RADIX4_EN
  assign w_window = {r_q[1:0], r_qm1};
`else
  assign w_window = {r_q[0], r_qm1};
`endif

  booth_recoder #(.WIDTH(WIDTH)) u_recoder (
    .i_window (w_window),
    .i_m      (r_m),
    .o_addend (w_addend)
  );

  // Multiplier is widened to QW bits so every window, including the last, sees its sign.
  assign w_mInit   = {signed_mode & A[WIDTH-1], A};
  assign w_qInit   = {{(QW-WIDTH){signed_mode & B[WIDTH-1]}}, B};
  assign w_sum     = r_acc + w_addend;
  assign w_shifted = $signed({w_sum, r_q, r_qm1}) >>> BOOTH_SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (en) begin
            r_m     <= w_mInit;
            r_q     <= w_qInit;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= CW'(ITER);
            r_state <= RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_acc <= w_shifted[AW+QW:QW+1];
          r_q   <= w_shifted[QW:1];
          r_qm1 <= w_shifted[0];
          r_cnt <= r_cnt - CW'(1);
          // After the final shift the full product sits in {acc, Q}.
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_out   <= w_shifted[2*WIDTH:1];
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Output = r_out;
  assign ready  = r_ready;
  assign busy   = r_busy;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench: directed 8-bit cases plus 2000 random back-to-back 16-bit products.
// Expected products come from plain integer multiplication; honours BOOTH_MUL_RADIX4_EN.
module tb_booth_multiplier_seq;

`ifdef BOOTH_MUL_RADIX4_EN
  localparam int ITER8  = 5;
  localparam int ITER16 = 9;
`else
  localparam int ITER8  = 9;
  localparam int ITER16 = 17;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en8, sm8, ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;
  logic        en16, sm16, ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] out16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .A(a8), .B(b8), .signed_mode(sm8),
    .Output(out8), .ready(ready8), .busy(busy8)
  );

  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .A(a16), .B(b16), .signed_mode(sm16),
    .Output(out16), .ready(ready16), .busy(busy16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: interpret operands per mode, multiply, keep the low 2*w bits.
  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                         input bit sm, input int w);
    longint     sa, sb;
    logic [63:0] p, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p    = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return p & mask;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // One 8-bit operation; inputs are scrambled after the start edge, optional en pulse mid-run.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit sm,
                               input string tag, input int pulseAt);
    int cycles;
    bit busyOk;
    en8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    tick();
    en8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
    checkOutput({tag, "_start"}, {62'd0, busy8, ready8}, 64'b10);
    cycles = 0;
    busyOk = 1'b1;
    while (!ready8 && cycles < 4 * ITER8) begin
      if (!busy8) busyOk = 1'b0;
      en8 = (cycles == pulseAt);
      if (en8) begin a8 = ~a; b8 = ~b; end
      tick();
      cycles++;
    end
    en8 = 1'b0;
    checkOutput({tag, "_lat"}, 64'(cycles), 64'(ITER8));
    checkOutput({tag, "_busy"}, {62'd0, busyOk, busy8}, 64'b10);
    checkOutput({tag, "_prod"}, 64'(out8), refMul(32'(a), 32'(b), sm, 8));
  endtask

  logic [15:0] expA, expB;
  logic        expSm;
  int          cycles;

  initial begin
    reset = 1'b1;
    en8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    en16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0;
    repeat (3) tick();
    checkOutput("rst8_out", 64'(out8), 64'd0);
    checkOutput("rst8_flags", {62'd0, ready8, busy8}, 64'd0);
    checkOutput("rst16_out", 64'(out16), 64'd0);
    checkOutput("rst16_flags", {62'd0, ready16, busy16}, 64'd0);
    reset = 1'b0;
    tick();

    applyStimulus(8'd129, 8'd1,   1'b0, "u129x1", -1);
    applyStimulus(8'd129, 8'd1,   1'b1, "s129x1", -1);
    applyStimulus(8'd255, 8'd255, 1'b0, "u255sq", -1);
    applyStimulus(8'h80,  8'h80,  1'b1, "sminsq", -1);
    applyStimulus(8'h80,  8'h7F,  1'b1, "sminmax", -1);
    checkOutput("known_0081", refMul(32'd129, 32'd1, 1'b0, 8), 64'h0081);

    repeat (3) tick();
    checkOutput("hold_out", 64'(out8), 64'hC080);
    checkOutput("hold_ready", {63'd0, ready8}, 64'd1);

    applyStimulus(8'd200, 8'd77, 1'b0, "midpulse", 2);

    // Abort with reset sampled on RUN cycle 4, then restart.
    en8 = 1'b1; a8 = 8'd37; b8 = 8'd91; sm8 = 1'b0;
    tick();
    en8 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_out", 64'(out8), 64'd0);
    checkOutput("midrst_flags", {62'd0, ready8, busy8}, 64'd0);
    repeat (ITER8 + 2) tick();
    checkOutput("midrst_idle", {46'd0, ready8, busy8, out8}, 64'd0);
    applyStimulus(8'd37, 8'd91, 1'b0, "restart", -1);

    // Reset and start on the same edge: reset wins, block stays idle.
    en8 = 1'b1; reset = 1'b1; a8 = 8'd5; b8 = 8'd7;
    tick();
    en8 = 1'b0; reset = 1'b0;
    checkOutput("rst_en", {46'd0, ready8, busy8, out8}, 64'd0);
    tick();
    checkOutput("rst_en_idle", {62'd0, ready8, busy8}, 64'd0);

    // Back-to-back random 16-bit products with en held high.
    en16 = 1'b1; a16 = pick16(); b16 = pick16(); sm16 = 1'($urandom);
    for (int n = 0; n < 2000; n++) begin
      expA = a16; expB = b16; expSm = sm16;
      tick();
      checkOutput("r16_start", {62'd0, busy16, ready16}, 64'b10);
      a16 = pick16(); b16 = pick16(); sm16 = 1'($urandom);
      cycles = 0;
      while (!ready16 && cycles < 4 * ITER16) begin
        tick();
        cycles++;
      end
      checkOutput("r16_lat", 64'(cycles), 64'(ITER16));
      checkOutput("r16_prod", 64'(out16), refMul(32'(expA), 32'(expB), expSm, 16));
    end
    en16 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
